// File: rtl/i2s_dac_tx_pkg.sv
// Shared audio constants for the I2S transmit path.
//   FRAME_BCLKS : bclk periods per stereo frame
//   SLOT_BCLKS  : bclk periods per channel slot
//   CNT_W/SLOT_W: counter widths derived from the above
//   is_legal_bitsize(): the sample widths the transmitter supports
package i2s_dac_tx_pkg;

  localparam int FRAME_BCLKS = 64;
  localparam int SLOT_BCLKS  = 32;
  localparam int CNT_W       = $clog2(FRAME_BCLKS);
  localparam int SLOT_W      = $clog2(SLOT_BCLKS);

  localparam int BITSIZE_16  = 16;
  localparam int BITSIZE_24  = 24;

  function automatic bit is_legal_bitsize(input int w);
    return (w == BITSIZE_16) || (w == BITSIZE_24);
  endfunction

endpackage

// File: rtl/i2s_shift_out.sv
// Per-slot parallel-load shifter for the I2S data line.
//   clk    : bclk, rising edge
//   reset  : synchronous active-high, clears the serial output
//   load   : capture par_in and drive its MSB on this edge
//   shift  : drive the next remaining bit on this edge
//   par_in : W-bit slot word
//   sdata  : registered serial bit; 0 whenever neither load nor shift
module i2s_shift_out #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] par_in,
  output logic         sdata
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sdata <= 1'b0;
    end else if (load) begin
      sdata <= par_in[W-1];
    end else if (shift) begin
      sdata <= sr[W-1];
    end else begin
      sdata <= 1'b0;
    end
  end

  // The shift register is pure data: a slot always starts with a load, so
  // its contents after reset never reach the output.
  always_ff @(posedge clk) begin
    if (load) begin
      sr <= {par_in[W-2:0], 1'b0};
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S stereo transmitter for a DAC, 64 bclk per frame, 32 per slot.
//   bclk     : the only clock, rising edge
//   reset    : synchronous active-high
//   enable   : 1 transmits samples, 0 transmits zeros (sampled at frame load)
//   left_in  : signed left sample
//   right_in : signed right sample
//   valid    : a left/right pair is offered
//   ready    : holding buffer is empty and can accept a pair
//   lrclk    : 0 = left slot, 1 = right slot
//   dacdat   : serial data, MSB first, one bclk after the lrclk edge
//   underrun : one-cycle pulse when a frame starts with nothing to send
module i2s_dac_tx
  import i2s_dac_tx_pkg::*;
#(
  parameter int BITSIZE = 16
) (
  input  logic                      bclk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [BITSIZE-1:0] left_in,
  input  logic signed [BITSIZE-1:0] right_in,
  input  logic                      valid,
  output logic                      ready,
  output logic                      lrclk,
  output logic                      dacdat,
  output logic                      underrun
);

  if (!is_legal_bitsize(BITSIZE)) begin : g_bad_bitsize
    $error("i2s_dac_tx: BITSIZE must be 16 or 24");
  end

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_BCLKS - 1);
  localparam logic [SLOT_W-1:0] LAST_SHIFT = SLOT_W'(BITSIZE - 1);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [SLOT_W-1:0] slot_pos;
  logic              frame_load;
  logic              accept;
  logic              have_src;
  logic              full;
  logic              armed;

  logic signed [BITSIZE-1:0] hold_l_p0;
  logic signed [BITSIZE-1:0] hold_r_p0;
  logic signed [BITSIZE-1:0] frame_l_p1;
  logic signed [BITSIZE-1:0] frame_r_p1;
  logic        [BITSIZE-1:0] slot_word;
  logic                      sh_load;
  logic                      sh_shift;

  assign cnt_nxt    = cnt + 1'b1;
  assign frame_load = (cnt == CNT_LAST);
  assign ready      = !full;
  assign accept     = valid && ready;
  // A pair offered on the load edge into an empty buffer feeds the frame directly.
  assign have_src   = full || valid;

  // Control: frame counter, frame clock, buffer occupancy, arming, underrun.
  always_ff @(posedge bclk) begin
    if (reset) begin
      cnt      <= CNT_LAST;
      lrclk    <= 1'b1;
      full     <= 1'b0;
      armed    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      lrclk    <= cnt_nxt[CNT_W-1];
      underrun <= 1'b0;
      if (accept) begin
        armed <= 1'b1;
      end
      if (frame_load) begin
        full <= 1'b0;
        if (enable && !have_src) begin
          underrun <= armed;
        end
      end else if (accept) begin
        full <= 1'b1;
      end
    end
  end

  // Stage p0: holding buffer, written on any accept outside the load edge.
  always_ff @(posedge bclk) begin
    if (accept && !frame_load) begin
      hold_l_p0 <= left_in;
      hold_r_p0 <= right_in;
    end
  end

  // Stage p1: frame registers, refreshed once per frame on the load edge.
  always_ff @(posedge bclk) begin
    if (reset) begin
      frame_l_p1 <= '0;
      frame_r_p1 <= '0;
    end else if (frame_load) begin
      if (enable && full) begin
        frame_l_p1 <= hold_l_p0;
        frame_r_p1 <= hold_r_p0;
      end else if (enable && valid) begin
        frame_l_p1 <= left_in;
        frame_r_p1 <= right_in;
      end else begin
        frame_l_p1 <= '0;
        frame_r_p1 <= '0;
      end
    end
  end

  // Serial stage: the shifter loads at slot position 0 so that the MSB lands
  // when the counter reaches position 1, leaving position 0 as the I2S delay bit.
  assign slot_pos  = cnt[SLOT_W-1:0];
  assign slot_word = cnt[CNT_W-1] ? frame_r_p1 : frame_l_p1;
  assign sh_load   = (slot_pos == '0);
  assign sh_shift  = (slot_pos != '0) && (slot_pos <= LAST_SHIFT);

  i2s_shift_out #(
    .W (BITSIZE)
  ) u_shift (
    .clk    (bclk),
    .reset  (reset),
    .load   (sh_load),
    .shift  (sh_shift),
    .par_in (slot_word),
    .sdata  (dacdat)
  );

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a 16-bit and a 24-bit instance share control inputs;
// a frame-level reference model predicts every output on every cycle.
module tb_i2s_dac_tx;

  logic bclk = 1'b0;
  logic reset, enable, valid;
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;
  logic ready16, lr16, dac16, und16;
  logic ready24, lr24, dac24, und24;

  always #5 bclk = ~bclk;

  i2s_dac_tx #(.BITSIZE(16)) dut16 (
    .bclk(bclk), .reset(reset), .enable(enable), .left_in(l16), .right_in(r16),
    .valid(valid), .ready(ready16), .lrclk(lr16), .dacdat(dac16), .underrun(und16)
  );

  i2s_dac_tx #(.BITSIZE(24)) dut24 (
    .bclk(bclk), .reset(reset), .enable(enable), .left_in(l24), .right_in(r24),
    .valid(valid), .ready(ready24), .lrclk(lr24), .dacdat(dac24), .underrun(und24)
  );

  typedef struct packed {
    logic [15:0] l16;
    logic [15:0] r16;
    logic [23:0] l24;
    logic [23:0] r24;
  } pair_t;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  pair_t buf_q[$];
  pair_t cur;
  int    m_cnt = 63;
  bit    m_armed = 0;
  bit    m_und = 0;
  bit    started = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Slot bit p of a w-bit word: 0 delay bit, then MSB..LSB, then padding zeros.
  function automatic logic slot_bit(input int c, input logic [23:0] lw,
                                    input logic [23:0] rw, input int w);
    int p;
    logic [23:0] word;
    p = c % 32;
    word = (c < 32) ? lw : rw;
    if (p >= 1 && p <= w) return word[w - p];
    return 1'b0;
  endfunction

  always @(posedge bclk) begin
    pair_t offered;
    bit acc;
    offered = '{l16: l16, r16: r16, l24: l24, r24: r24};
    if (reset) begin
      m_cnt = 63;
      buf_q.delete();
      cur = '0;
      m_armed = 0;
      m_und = 0;
    end else begin
      acc = valid && (buf_q.size() == 0);
      m_und = 0;
      if (m_cnt == 63) begin
        pair_t src;
        bit have;
        have = 1;
        if (buf_q.size() != 0) src = buf_q.pop_front();
        else if (valid) src = offered;
        else have = 0;
        if (!enable) cur = '0;
        else if (have) cur = src;
        else begin
          cur = '0;
          m_und = m_armed;
        end
      end else if (acc) begin
        buf_q.push_back(offered);
      end
      if (acc) m_armed = 1;
      m_cnt = (m_cnt + 1) % 64;
    end
    started = 1;
  end

  always @(negedge bclk) begin
    if (started) begin
      chk("lrclk16", lr16, m_cnt >= 32);
      chk("lrclk24", lr24, m_cnt >= 32);
      chk("dacdat16", dac16, slot_bit(m_cnt, {8'h0, cur.l16}, {8'h0, cur.r16}, 16));
      chk("dacdat24", dac24, slot_bit(m_cnt, cur.l24, cur.r24, 24));
      chk("ready16", ready16, buf_q.size() == 0);
      chk("ready24", ready24, buf_q.size() == 0);
      chk("underrun16", und16, m_und);
      chk("underrun24", und24, m_und);
    end
  end

  task automatic step();
    @(posedge bclk);
    #2;
  endtask

  task automatic wait_cnt(input int k);
    for (int n = 0; n < 200; n++) begin
      if (m_cnt == k) return;
      step();
    end
    mismatched++;
    $display("FAIL wait_cnt: counter never reached %0d (now %0d)", k, m_cnt);
  endtask

  task automatic set_pair(input logic [15:0] a, input logic [15:0] b,
                          input logic [23:0] c, input logic [23:0] d);
    l16 = a; r16 = b; l24 = c; r24 = d;
  endtask

  initial begin
    logic [63:0] cap, ucap;
    int lo, ones, u, rd, vp;

    reset = 1'b1; enable = 1'b1; valid = 1'b0;
    set_pair(16'h0, 16'h0, 24'h0, 24'h0);
    repeat (3) step();
    chk("reset_lrclk", lr16, 1'b1);
    chk("reset_ready", ready16, 1'b1);
    chk("reset_dacdat", dac24, 1'b0);
    reset = 1'b0;

    // Idle after reset: square lrclk, silent data, no underrun.
    lo = 0; ones = 0; u = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge bclk);
      lo += (lr16 == 1'b0);
      ones += dac16 + dac24;
      u += und16 + und24;
    end
    chk("idle_lrclk_low_cycles", lo, 32);
    chk("idle_dac_ones", ones, 0);
    chk("idle_underrun", u, 0);
    step();

    // Pair buffered at cnt 10 appears in the next frame.
    wait_cnt(10);
    set_pair(16'h8001, 16'h7FFE, 24'h123456, 24'hABCDEF);
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_cnt(0);
    cap = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge bclk);
      cap = {cap[62:0], dac16};
    end
    chk("frame_8001_7ffe", cap, {32'h4000_8000, 32'h3FFF_0000});
    step();

    // Direct load: offered at cnt 63 with empty buffer.
    wait_cnt(63);
    set_pair(16'hA5A5, 16'h0F0F, 24'h800001, 24'h7FFFFE);
    valid = 1'b1;
    step();
    valid = 1'b0;
    cap = '0; u = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge bclk);
      cap = {cap[62:0], dac16};
      u += und16;
    end
    chk("frame_direct_a5a5_0f0f", cap, {32'h52D2_8000, 32'h0787_8000});
    chk("direct_underrun", u, 0);
    step();

    // One pair, then starve: underrun exactly on the cnt 0 of the frame after.
    wait_cnt(20);
    set_pair(16'h1111, 16'h2222, 24'h333333, 24'h444444);
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_cnt(0);
    wait_cnt(63);
    step();
    cap = '0; ucap = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge bclk);
      cap = {cap[62:0], dac24};
      ucap = {ucap[62:0], und16};
    end
    chk("starved_frame_data", cap, 64'h0);
    chk("starved_underrun_pos", ucap, 64'h8000_0000_0000_0000);
    step();

    // Full buffer with valid held: ready opens for one cycle per frame.
    wait_cnt(5);
    set_pair(16'h5A5A, 16'hC3C3, 24'h5A5A5A, 24'hC3C3C3);
    valid = 1'b1;
    step();
    rd = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge bclk);
      rd += ready16;
    end
    chk("held_valid_ready_cycles", rd, 2);

    // Disabled: all-ones samples still produce silent frames.
    step();
    enable = 1'b0;
    set_pair(16'hFFFF, 16'hFFFF, 24'hFFFFFF, 24'hFFFFFF);
    wait_cnt(0);
    ones = 0; u = 0; rd = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge bclk);
      ones += dac24 + dac16;
      u += und24;
      rd += ready24;
    end
    chk("disabled_dac_ones", ones, 0);
    chk("disabled_underrun", u, 0);
    chk("disabled_ready_cycles", rd, 2);
    step();

    // Reset mid-frame.
    wait_cnt(40);
    reset = 1'b1;
    step();
    @(negedge bclk);
    chk("midreset_dacdat", dac24, 1'b0);
    chk("midreset_lrclk", lr24, 1'b1);
    chk("midreset_ready", ready24, 1'b1);
    step();
    reset = 1'b0;
    enable = 1'b1;
    valid = 1'b0;

    // Randomized traffic.
    vp = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 256 == 0) begin
        case ($urandom_range(0, 2))
          0: vp = 10;
          1: vp = 50;
          default: vp = 95;
        endcase
      end
      valid = ($urandom_range(0, 99) < vp);
      set_pair(16'($urandom), 16'($urandom), 24'($urandom), 24'($urandom));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      reset = ($urandom_range(0, 1499) == 0);
      step();
    end
    reset = 1'b0;
    valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
